// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised X/Y/Z accumulator CPU:
// opcodes, FSM state encoding and ALU operation codes.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDX  = 4'd1;
  localparam logic [3:0] OP_LDY  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_MOVZ = 4'd9;
  localparam logic [3:0] OP_MOVX = 4'd10;
  localparam logic [3:0] OP_CLRY = 4'd11;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_JZ   = 4'd13;
  localparam logic [3:0] OP_JC   = 4'd14;
  localparam logic [3:0] OP_HLT  = 4'd15;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5
  } alu_op_t;

  // Only opcodes 3..8 use the ALU result; the rest map to a don't-care ADD.
  function automatic alu_op_t alu_op_of(input logic [3:0] opc);
    case (opc)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_NOT:  return ALU_NOT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ula_param.sv
// Combinational ALU: result = b op a (b is Y, a is X).
// carry is the ADD carry-out or the SUB borrow; logic ops always return carry 0.
module ula_param
  import cpu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] wide;

  // One extra bit catches the carry on ADD and the borrow (b < a) on SUB.
  always_comb begin
    wide = '0;
    case (op)
      ALU_ADD: wide = {1'b0, b} + {1'b0, a};
      ALU_SUB: wide = {1'b0, b} - {1'b0, a};
      ALU_AND: wide = {1'b0, b & a};
      ALU_OR:  wide = {1'b0, b | a};
      ALU_XOR: wide = {1'b0, b ^ a};
      ALU_NOT: wide = {1'b0, ~b};
      default: wide = '0;
    endcase
  end

  assign result = wide[WIDTH-1:0];
  assign carry  = wide[WIDTH];

endmodule

// File: rtl/cpu_parametrizada.sv
// Parametrised X/Y/Z accumulator CPU: two-cycle fetch/execute sequencer with
// zero/carry flags, jumps, halt and a run/stall input.
//
//   state    | meaning
//   ST_FETCH | latch instr into IR when run=1, otherwise hold
//   ST_EXEC  | execute IR, update pc, return to FETCH (HALT on HLT)
//   ST_HALT  | absorbing; only reset leaves it
module cpu_parametrizada
  import cpu_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PC_WIDTH = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                run,
  input  logic [WIDTH+3:0]    instr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [WIDTH-1:0]    out_x,
  output logic [WIDTH-1:0]    out_y,
  output logic [WIDTH-1:0]    out_z,
  output logic [3:0]          opcode,
  output logic                flag_z,
  output logic                flag_c,
  output logic                halted
);

  state_t              state_q, state_d;
  logic [WIDTH+3:0]    ir_q, ir_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]    x_q, x_d;
  logic [WIDTH-1:0]    y_q, y_d;
  logic [WIDTH-1:0]    z_q, z_d;
  logic                fz_q, fz_d;
  logic                fc_q, fc_d;

  logic [3:0]          ir_op;
  logic [WIDTH-1:0]    imm;
  logic [PC_WIDTH-1:0] jmp_tgt;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0]    alu_res;
  logic                alu_carry;

  assign ir_op   = ir_q[WIDTH+3:WIDTH];
  assign imm     = ir_q[WIDTH-1:0];
  assign jmp_tgt = imm[PC_WIDTH-1:0];
  assign pc_inc  = pc_q + PC_WIDTH'(1);

  ula_param #(.WIDTH(WIDTH)) u_ula (
    .op     (alu_op_of(ir_op)),
    .a      (x_q),
    .b      (y_q),
    .result (alu_res),
    .carry  (alu_carry)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    fz_d    = fz_q;
    fc_d    = fc_q;
    case (state_q)
      ST_FETCH: begin
        if (run) begin
          ir_d    = instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        case (ir_op)
          OP_LDX: x_d = imm;
          OP_LDY: y_d = imm;
          // ALU carry is already 0 for the logic ops, which clears flag_c.
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
            y_d  = alu_res;
            fz_d = (alu_res == '0);
            fc_d = alu_carry;
          end
          OP_MOVZ: z_d = y_q;
          OP_MOVX: x_d = z_q;
          OP_CLRY: y_d = '0;
          OP_JMP:  pc_d = jmp_tgt;
          OP_JZ:   if (fz_q) pc_d = jmp_tgt;
          OP_JC:   if (fc_q) pc_d = jmp_tgt;
          OP_HLT: begin
            pc_d    = pc_q;
            state_d = ST_HALT;
          end
          default: ;
        endcase
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      pc_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      fz_q    <= fz_d;
      fc_q    <= fc_d;
    end
  end

  assign pc     = pc_q;
  assign out_x  = x_q;
  assign out_y  = y_q;
  assign out_z  = z_q;
  assign opcode = ir_op;
  assign flag_z = fz_q;
  assign flag_c = fc_q;
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_parametrizada.sv
// Bench for cpu_parametrizada: a 4/4 and an 8/6 instance run from bench-owned
// program memories and are compared every cycle against an instruction-level model.
module tb_cpu_parametrizada;

  localparam int NOP = 0, LDX = 1, LDY = 2, ADD = 3, SUB = 4, ANDI = 5, ORI = 6,
                 XORI = 7, NOTI = 8, MOVZ = 9, MOVX = 10, CLRY = 11, JMP = 12,
                 JZ = 13, JC = 14, HLT = 15;

  logic clock = 1'b0;
  logic reset_n;
  logic run;

  logic [7:0]  mem4 [16];
  logic [11:0] mem8 [64];

  logic [7:0]  instr4;
  logic [3:0]  pc4;
  logic [3:0]  x4, y4, z4, opc4;
  logic        fz4, fc4, h4;

  logic [11:0] instr8;
  logic [5:0]  pc8;
  logic [7:0]  x8, y8, z8;
  logic [3:0]  opc8;
  logic        fz8, fc8, h8;

  assign instr4 = mem4[pc4];
  assign instr8 = mem8[pc8];

  always #5 clock = ~clock;

  cpu_parametrizada #(.WIDTH(4), .PC_WIDTH(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .run(run), .instr(instr4), .pc(pc4),
    .out_x(x4), .out_y(y4), .out_z(z4), .opcode(opc4),
    .flag_z(fz4), .flag_c(fc4), .halted(h4)
  );

  cpu_parametrizada #(.WIDTH(8), .PC_WIDTH(6)) dut8 (
    .clock(clock), .reset_n(reset_n), .run(run), .instr(instr8), .pc(pc8),
    .out_x(x8), .out_y(y8), .out_z(z8), .opcode(opc8),
    .flag_z(fz8), .flag_c(fc8), .halted(h8)
  );

  // st: 0 waiting to fetch, 1 instruction fetched, 2 halted
  typedef struct {
    int st; int pc; int x; int y; int z; int fz; int fc; int ir;
  } mdl_t;

  mdl_t m4, m8;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  function automatic mdl_t step(mdl_t m, int w, int pw, bit rst, bit go, int ins);
    mdl_t r;
    int mask, pmask, op, imm, nxt, s;
    r = m;
    mask  = (1 << w) - 1;
    pmask = (1 << pw) - 1;
    if (rst) begin
      r = '{0, 0, 0, 0, 0, 0, 0, 0};
      return r;
    end
    if (m.st == 0) begin
      if (go) begin
        r.ir = ins & ((1 << (w + 4)) - 1);
        r.st = 1;
      end
    end else if (m.st == 1) begin
      op  = m.ir >> w;
      imm = m.ir & mask;
      nxt = (m.pc + 1) & pmask;
      r.st = 0;
      case (op)
        LDX:  r.x = imm;
        LDY:  r.y = imm;
        ADD:  begin s = m.y + m.x; r.fc = (s > mask); r.y = s & mask; end
        SUB:  begin r.fc = (m.x > m.y); r.y = (m.y - m.x) & mask; end
        ANDI: begin r.y = m.y & m.x; r.fc = 0; end
        ORI:  begin r.y = m.y | m.x; r.fc = 0; end
        XORI: begin r.y = m.y ^ m.x; r.fc = 0; end
        NOTI: begin r.y = (~m.y) & mask; r.fc = 0; end
        MOVZ: r.z = m.y;
        MOVX: r.x = m.z;
        CLRY: r.y = 0;
        JMP:  nxt = imm & pmask;
        JZ:   if (m.fz != 0) nxt = imm & pmask;
        JC:   if (m.fc != 0) nxt = imm & pmask;
        HLT:  begin nxt = m.pc; r.st = 2; end
        default: ;
      endcase
      if (op >= ADD && op <= NOTI) r.fz = (r.y == 0);
      r.pc = nxt;
    end
    return r;
  endfunction

  always @(posedge clock) begin
    m4 = step(m4, 4, 4, !reset_n, run, int'(mem4[m4.pc[3:0]]));
    m8 = step(m8, 8, 6, !reset_n, run, int'(mem8[m8.pc[5:0]]));
  end

  task automatic cmp(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      cmp("pc4", int'(pc4), m4.pc);
      cmp("x4", int'(x4), m4.x);
      cmp("y4", int'(y4), m4.y);
      cmp("z4", int'(z4), m4.z);
      cmp("opcode4", int'(opc4), m4.ir >> 4);
      cmp("flag_z4", int'(fz4), m4.fz);
      cmp("flag_c4", int'(fc4), m4.fc);
      cmp("halted4", int'(h4), int'(m4.st == 2));
      cmp("pc8", int'(pc8), m8.pc);
      cmp("x8", int'(x8), m8.x);
      cmp("y8", int'(y8), m8.y);
      cmp("z8", int'(z8), m8.z);
      cmp("opcode8", int'(opc8), m8.ir >> 8);
      cmp("flag_z8", int'(fz8), m8.fz);
      cmp("flag_c8", int'(fc8), m8.fc);
      cmp("halted8", int'(h8), int'(m8.st == 2));
    end
  end

  function automatic logic [7:0] e4(input int op, input int imm);
    return 8'((op << 4) | (imm & 15));
  endfunction

  function automatic logic [11:0] e8(input int op, input int imm);
    return 12'((op << 8) | (imm & 255));
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 16; i++) mem4[i] = e4(NOP, 0);
    for (int i = 0; i < 64; i++) mem8[i] = e8(NOP, 0);
  endtask

  initial begin
    m4 = '{0, 0, 0, 0, 0, 0, 0, 0};
    m8 = '{0, 0, 0, 0, 0, 0, 0, 0};
    reset_n = 1'b0;
    run     = 1'b1;
    clear_mems();
    mem4[0] = e4(LDX, 7);
    mem8[0] = e8(LDX, 7);

    // Reset held for two edges with an LDX waiting at address 0.
    tick(1);
    chk_en = 1'b1;
    tick(1);
    cmp("rst_pc", int'(pc4), 0);
    cmp("rst_x", int'(x4), 0);
    cmp("rst_halted", int'(h4), 0);
    reset_n = 1'b1;
    tick(2);
    cmp("first_ldx", int'(x4), 7);

    // Basic program; the 8-bit instance runs its carry/jump program alongside.
    reset_n = 1'b0;
    clear_mems();
    mem4[0] = e4(LDX, 3); mem4[1] = e4(LDY, 5); mem4[2] = e4(ADD, 0);
    mem4[3] = e4(MOVZ, 0); mem4[4] = e4(HLT, 0);
    mem8[0] = e8(LDX, 200); mem8[1] = e8(LDY, 100); mem8[2] = e8(ADD, 0);
    mem8[3] = e8(JMP, 255); mem8[63] = e8(HLT, 0);
    tick(1);
    reset_n = 1'b1;
    tick(5);
    cmp("opc_add", int'(opc4), ADD);
    tick(1);
    cmp("basic_y", int'(y4), 8);
    cmp("w8_y", int'(y8), 44);
    cmp("w8_c", int'(fc8), 1);
    tick(2);
    cmp("basic_z", int'(z4), 8);
    cmp("w8_jmp", int'(pc8), 63);
    tick(2);
    cmp("basic_halt", int'(h4), 1);
    cmp("basic_pc", int'(pc4), 4);
    cmp("basic_c", int'(fc4), 0);
    cmp("basic_z_flag", int'(fz4), 0);
    cmp("w8_halt", int'(h8), 1);
    tick(4);
    cmp("halt_pc_frozen", int'(pc4), 4);

    // Flags, conditional jumps and pc wrap.
    reset_n = 1'b0;
    mem4[0] = e4(LDX, 9); mem4[1] = e4(LDY, 9); mem4[2] = e4(ADD, 0);
    mem4[3] = e4(LDX, 2); mem4[4] = e4(SUB, 0); mem4[5] = e4(JZ, 12);
    for (int i = 6; i < 12; i++) mem4[i] = e4(NOP, 0);
    mem4[12] = e4(JC, 5); mem4[13] = e4(JMP, 15); mem4[14] = e4(NOP, 0);
    mem4[15] = e4(NOP, 0);
    tick(1);
    reset_n = 1'b1;
    tick(6);
    cmp("flags_add_y", int'(y4), 2);
    cmp("flags_add_c", int'(fc4), 1);
    tick(4);
    cmp("flags_sub_y", int'(y4), 0);
    cmp("flags_sub_z", int'(fz4), 1);
    cmp("flags_sub_c", int'(fc4), 0);
    tick(2);
    cmp("jz_taken", int'(pc4), 12);
    tick(2);
    cmp("jc_not_taken", int'(pc4), 13);
    tick(2);
    cmp("jmp_15", int'(pc4), 15);
    tick(2);
    cmp("pc_wrap", int'(pc4), 0);
    run = 1'b0;
    tick(5);
    cmp("stall_pc", int'(pc4), 0);
    cmp("stall_x", int'(x4), 2);
    run = 1'b1;

    // run dropped during EXEC, then reset during EXEC.
    reset_n = 1'b0;
    clear_mems();
    mem4[0] = e4(LDY, 4); mem4[1] = e4(LDX, 5);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    run = 1'b0;
    tick(1);
    cmp("exec_no_stall_y", int'(y4), 4);
    cmp("exec_no_stall_pc", int'(pc4), 1);
    run = 1'b1;
    tick(1);
    reset_n = 1'b0;
    tick(1);
    cmp("rst_exec_x", int'(x4), 0);
    cmp("rst_exec_y", int'(y4), 0);
    cmp("rst_exec_pc", int'(pc4), 0);
    cmp("rst_exec_opc", int'(opc4), 0);

    // Random programs, random run, occasional reset with a fresh program.
    for (int c = 0; c < 3000; c++) begin
      if (c == 0 || $urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        for (int i = 0; i < 16; i++) mem4[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) mem8[i] = 12'($urandom);
      end else begin
        reset_n = 1'b1;
      end
      run = ($urandom_range(0, 3) != 0);
      tick(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
